// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multi-cycle controller (master) and the RV64I datapath/memory (slave).
interface multicycle_control_if #(
    parameter int unsigned COUNT_W = 64
);
    logic [6:0]         opcode;
    logic               zero;
    logic               mem_ready;
    logic [2:0]         state;
    logic               mem_req;
    logic               mem_read;
    logic               mem_write;
    logic               iord;
    logic               ir_write;
    logic               pc_write;
    logic               pc_src;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic               reg_write;
    logic               mem_to_reg;
    logic               instr_done;
    logic               illegal;
    logic [COUNT_W-1:0] instret;

    modport master (
        input  opcode, zero, mem_ready,
        output state, mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, instr_done, illegal,
               instret
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  state, mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, instr_done, illegal,
               instret
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV64I control FSM (R-type, ld, sd, beq) over a unified memory port,
// with a retired-instruction counter.
module multicycle_control #(
    parameter int unsigned COUNT_W = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_if.master   bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_e             state_q, state_d;
    logic [6:0]         op_q, op_d;
    logic [COUNT_W-1:0] instret_q, instret_d;

    logic       mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_src;
    logic       alu_src_a, reg_write, mem_to_reg, instr_done, illegal;
    logic [1:0] alu_src_b, alu_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mem_req    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;

        // Reset gates every control output, so the case body only runs out of reset.
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    if (bus.mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    op_d = bus.opcode;
                    if (bus.opcode == OP_R || bus.opcode == OP_LD ||
                        bus.opcode == OP_SD || bus.opcode == OP_BEQ) begin
                        state_d = S_EXEC;
                    end else begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    case (op_q)
                        OP_R: begin
                            alu_op  = 2'b10;
                            state_d = S_WB;
                        end
                        OP_LD, OP_SD: begin
                            alu_src_b = 2'b10;
                            state_d   = S_MEM;
                        end
                        OP_BEQ: begin
                            alu_op     = 2'b01;
                            pc_write   = bus.zero;
                            pc_src     = bus.zero;
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                        default: state_d = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    mem_req   = 1'b1;
                    iord      = 1'b1;
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    mem_read  = (op_q == OP_LD);
                    mem_write = (op_q == OP_SD);
                    if (bus.mem_ready) begin
                        if (op_q == OP_LD) begin
                            state_d = S_WB;
                        end else begin
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (op_q == OP_LD);
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end

        instret_d = instr_done ? instret_q + COUNT_W'(1) : instret_q;
    end

    assign bus.state      = state_q;
    assign bus.mem_req    = mem_req;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.iord       = iord;
    assign bus.ir_write   = ir_write;
    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.reg_write  = reg_write;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.instr_done = instr_done;
    assign bus.illegal    = illegal;
    assign bus.instret    = instret_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven cycle-by-cycle bench for multicycle_control, plus a counter wrap sequence on a 4-bit instance.
module tb_multicycle_control;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    multicycle_control_if #(.COUNT_W(64)) bus ();
    multicycle_control_if #(.COUNT_W(4))  bus4 ();

    multicycle_control #(.COUNT_W(64)) dut (.clk(clk), .reset(rst), .bus(bus.master));
    multicycle_control #(.COUNT_W(4))  dut4 (.clk(clk), .reset(rst), .bus(bus4.master));

    // {mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a,
    //  alu_src_b[1:0], alu_op[1:0], reg_write, mem_to_reg, instr_done, illegal}
    logic [15:0] ctl;
    assign ctl = {bus.mem_req, bus.mem_read, bus.mem_write, bus.iord, bus.ir_write,
                  bus.pc_write, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                  bus.reg_write, bus.mem_to_reg, bus.instr_done, bus.illegal};

    localparam logic [15:0] C_OFF  = 16'h0000;
    localparam logic [15:0] C_FW   = 16'hC040;
    localparam logic [15:0] C_FR   = 16'hCC40;
    localparam logic [15:0] C_ILL  = 16'h0001;
    localparam logic [15:0] C_EXR  = 16'h0120;
    localparam logic [15:0] C_EXM  = 16'h0180;
    localparam logic [15:0] C_EXB0 = 16'h0112;
    localparam logic [15:0] C_EXB1 = 16'h0712;
    localparam logic [15:0] C_MLD  = 16'hD180;
    localparam logic [15:0] C_MSDW = 16'hB180;
    localparam logic [15:0] C_MSDR = 16'hB182;
    localparam logic [15:0] C_WBR  = 16'h000A;
    localparam logic [15:0] C_WBL  = 16'h000E;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        z;
        logic        rdy;
        logic [2:0]  st;
        logic [15:0] ctl;
        logic [63:0] inst;
    } vec_t;

    vec_t vt[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic r, logic [6:0] op, logic z, logic rdy,
                                logic [2:0] st, logic [15:0] c, logic [63:0] inst);
        vec_t v;
        v.rst = r; v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.ctl = c; v.inst = inst;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.opcode = '0;  bus.zero = 1'b0;  bus.mem_ready = 1'b0;
        bus4.opcode = '0; bus4.zero = 1'b0; bus4.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Inputs apply for one cycle; expectations are the outputs seen before the next edge.
        vt.push_back(mk(1, 7'h00, 0, 1, 3'd0, C_OFF,  0));
        // R-type, zero-wait
        vt.push_back(mk(0, 7'h00, 0, 1, 3'd0, C_FR,   0));
        vt.push_back(mk(0, 7'h33, 0, 1, 3'd1, C_OFF,  0));
        vt.push_back(mk(0, 7'h00, 1, 1, 3'd2, C_EXR,  0));
        vt.push_back(mk(0, 7'h00, 0, 1, 3'd4, C_WBR,  0));
        // ld with two MEM wait cycles
        vt.push_back(mk(0, 7'h00, 0, 1, 3'd0, C_FR,   1));
        vt.push_back(mk(0, 7'h03, 0, 1, 3'd1, C_OFF,  1));
        vt.push_back(mk(0, 7'h00, 0, 1, 3'd2, C_EXM,  1));
        vt.push_back(mk(0, 7'h00, 0, 0, 3'd3, C_MLD,  1));
        vt.push_back(mk(0, 7'h00, 0, 0, 3'd3, C_MLD,  1));
        vt.push_back(mk(0, 7'h00, 0, 1, 3'd3, C_MLD,  1));
        vt.push_back(mk(0, 7'h00, 0, 1, 3'd4, C_WBL,  1));
        // sd with one FETCH wait, zero-wait MEM
        vt.push_back(mk(0, 7'h00, 0, 0, 3'd0, C_FW,   2));
        vt.push_back(mk(0, 7'h00, 0, 1, 3'd0, C_FR,   2));
        vt.push_back(mk(0, 7'h23, 0, 1, 3'd1, C_OFF,  2));
        vt.push_back(mk(0, 7'h00, 0, 1, 3'd2, C_EXM,  2));
        vt.push_back(mk(0, 7'h00, 0, 1, 3'd3, C_MSDR, 2));
        // beq taken, then not taken
        vt.push_back(mk(0, 7'h00, 0, 1, 3'd0, C_FR,   3));
        vt.push_back(mk(0, 7'h63, 0, 1, 3'd1, C_OFF,  3));
        vt.push_back(mk(0, 7'h00, 1, 1, 3'd2, C_EXB1, 3));
        vt.push_back(mk(0, 7'h00, 0, 1, 3'd0, C_FR,   4));
        vt.push_back(mk(0, 7'h63, 1, 1, 3'd1, C_OFF,  4));
        vt.push_back(mk(0, 7'h00, 0, 1, 3'd2, C_EXB0, 4));
        // unsupported opcode
        vt.push_back(mk(0, 7'h00, 0, 1, 3'd0, C_FR,   5));
        vt.push_back(mk(0, 7'h13, 0, 1, 3'd1, C_ILL,  5));
        vt.push_back(mk(0, 7'h00, 0, 1, 3'd0, C_FR,   5));
        // sd interrupted by reset while waiting in MEM
        vt.push_back(mk(0, 7'h23, 0, 1, 3'd1, C_OFF,  5));
        vt.push_back(mk(0, 7'h00, 0, 1, 3'd2, C_EXM,  5));
        vt.push_back(mk(0, 7'h00, 0, 0, 3'd3, C_MSDW, 5));
        vt.push_back(mk(1, 7'h00, 0, 0, 3'd3, C_OFF,  5));
        vt.push_back(mk(0, 7'h00, 0, 0, 3'd0, C_FW,   0));

        for (int i = 0; i < vt.size(); i++) begin
            rst           = vt[i].rst;
            bus.opcode    = vt[i].op;
            bus.zero      = vt[i].z;
            bus.mem_ready = vt[i].rdy;
            #1;
            chk($sformatf("row%0d state", i),   64'(bus.state), 64'(vt[i].st));
            chk($sformatf("row%0d ctl", i),     64'(ctl),       64'(vt[i].ctl));
            chk($sformatf("row%0d instret", i), bus.instret,    vt[i].inst);
            @(posedge clk);
            #1;
        end

        // Counter wrap: sixteen not-taken beqs on the 4-bit instance, 15 -> 0 on the last one.
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus4.mem_ready = 1'b1;
            bus4.opcode    = 7'h00;
            bus4.zero      = 1'b0;
            @(posedge clk); #1;
            bus4.opcode = 7'h63;
            @(posedge clk); #1;
            bus4.opcode = 7'h00;
            #1;
            chk($sformatf("wrap%0d done", i), 64'(bus4.instr_done), 64'(1));
            @(posedge clk); #1;
            chk($sformatf("wrap%0d instret", i), 64'(bus4.instret), 64'((i + 1) % 16));
            chk($sformatf("wrap%0d state", i),   64'(bus4.state),   64'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
